adma_slv_axi_b: RTL and testbench

//  AXI slave-side write-response generator: the responder end of the B channel.

---
 rtl/adma_slv_axi_b.sv | 100 ++++++++++
 tb/tb_adma_slv_axi_b.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adma_slv_axi_b.sv
// AXI slave B-channel responder: queues AW info and pairs each entry with a burst-complete event.
// Latency: completion handshake in cycle N gives BVALID in cycle N+1; one response per cycle.
// Backpressure: a full AW queue drops aw_rdy_o; a stalled B register or an empty queue drops wd_rdy_o.
module adma_slv_axi_b #(
    parameter int SLV_ID_W     = 5,
    parameter int ATX_RESP_W   = 2,
    parameter int ATX_NUM_OSTD = 4,
    parameter int OSTD_CNT_W   = $clog2(ATX_NUM_OSTD + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SLV_ID_W-1:0]   aw_id_i,
    input  logic                  aw_decerr_i,
    input  logic                  aw_vld_i,
    output logic                  aw_rdy_o,
    input  logic                  wd_err_i,
    input  logic                  wd_vld_i,
    output logic                  wd_rdy_o,
    output logic [SLV_ID_W-1:0]   s_bid_o,
    output logic [ATX_RESP_W-1:0] s_bresp_o,
    output logic                  s_bvalid_o,
    input  logic                  s_bready_i,
    output logic [OSTD_CNT_W-1:0] ostd_cnt_o
);

    localparam int PTR_W = $clog2(ATX_NUM_OSTD);
    localparam logic [ATX_RESP_W-1:0] RESP_OKAY   = ATX_RESP_W'(2'b00);
    localparam logic [ATX_RESP_W-1:0] RESP_SLVERR = ATX_RESP_W'(2'b10);
    localparam logic [ATX_RESP_W-1:0] RESP_DECERR = ATX_RESP_W'(2'b11);

    logic [PTR_W:0]        wr_ptr;
    logic [PTR_W:0]        rd_ptr;
    logic [PTR_W:0]        aw_cnt;
    logic [SLV_ID_W-1:0]   id_q     [ATX_NUM_OSTD];
    logic                  decerr_q [ATX_NUM_OSTD];
    logic                  aw_full;
    logic                  aw_empty;
    logic                  aw_push;
    logic                  wd_pop;
    logic [SLV_ID_W-1:0]   head_id;
    logic                  head_decerr;
    logic [ATX_RESP_W-1:0] head_resp;

    assign aw_cnt   = wr_ptr - rd_ptr;
    assign aw_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign aw_empty = (wr_ptr == rd_ptr);

    // Ready flags come only from registered pointers, so a pop never frees a slot in its own cycle.
    assign aw_rdy_o = rst | ~aw_full;
    assign wd_rdy_o = ~rst & ~aw_empty & (~s_bvalid_o | s_bready_i);

    assign aw_push  = aw_vld_i & aw_rdy_o;
    assign wd_pop   = wd_vld_i & wd_rdy_o;

    assign head_id     = id_q[rd_ptr[PTR_W-1:0]];
    assign head_decerr = decerr_q[rd_ptr[PTR_W-1:0]];
    assign head_resp   = head_decerr ? RESP_DECERR :
                         (wd_err_i   ? RESP_SLVERR : RESP_OKAY);

    assign ostd_cnt_o = OSTD_CNT_W'(aw_cnt) + OSTD_CNT_W'(s_bvalid_o);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (aw_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (wd_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Entry storage needs no reset: entries are only read between valid pointers.
    always_ff @(posedge clk) begin
        if (aw_push && !rst) begin
            id_q[wr_ptr[PTR_W-1:0]]     <= aw_id_i;
            decerr_q[wr_ptr[PTR_W-1:0]] <= aw_decerr_i;
        end
    end

    // A load in the handshake cycle overrides the clear, keeping one response per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_bvalid_o <= 1'b0;
            s_bid_o    <= '0;
            s_bresp_o  <= '0;
        end else if (wd_pop) begin
            s_bvalid_o <= 1'b1;
            s_bid_o    <= head_id;
            s_bresp_o  <= head_resp;
        end else if (s_bready_i) begin
            s_bvalid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adma_slv_axi_b.sv
module tb_adma_slv_axi_b;

    logic       clk;
    logic       rst;
    logic [4:0] aw_id_i;
    logic       aw_decerr_i;
    logic       aw_vld_i;
    logic       aw_rdy_o;
    logic       wd_err_i;
    logic       wd_vld_i;
    logic       wd_rdy_o;
    logic [4:0] s_bid_o;
    logic [1:0] s_bresp_o;
    logic       s_bvalid_o;
    logic       s_bready_i;
    logic [2:0] ostd_cnt_o;

    int n_cmp;
    int n_err;

    adma_slv_axi_b #(
        .SLV_ID_W    (5),
        .ATX_RESP_W  (2),
        .ATX_NUM_OSTD(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .aw_id_i    (aw_id_i),
        .aw_decerr_i(aw_decerr_i),
        .aw_vld_i   (aw_vld_i),
        .aw_rdy_o   (aw_rdy_o),
        .wd_err_i   (wd_err_i),
        .wd_vld_i   (wd_vld_i),
        .wd_rdy_o   (wd_rdy_o),
        .s_bid_o    (s_bid_o),
        .s_bresp_o  (s_bresp_o),
        .s_bvalid_o (s_bvalid_o),
        .s_bready_i (s_bready_i),
        .ostd_cnt_o (ostd_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are then changed 1ns after the edge.
    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic push_aw(input logic [4:0] id, input logic dec);
        aw_vld_i = 1'b1; aw_id_i = id; aw_decerr_i = dec;
        go();
        aw_vld_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        go(); go();
        smp();
        n_cmp++; if (s_bvalid_o !== 1'b0) begin n_err++; $display("FAIL rst_bvalid got %0d want 0", s_bvalid_o); end
        n_cmp++; if (s_bid_o !== 5'd0) begin n_err++; $display("FAIL rst_bid got %0d want 0", s_bid_o); end
        n_cmp++; if (s_bresp_o !== 2'd0) begin n_err++; $display("FAIL rst_bresp got %0d want 0", s_bresp_o); end
        n_cmp++; if (ostd_cnt_o !== 3'd0) begin n_err++; $display("FAIL rst_ostd got %0d want 0", ostd_cnt_o); end
        n_cmp++; if (aw_rdy_o !== 1'b1) begin n_err++; $display("FAIL rst_aw_rdy got %0d want 1", aw_rdy_o); end
        n_cmp++; if (wd_rdy_o !== 1'b0) begin n_err++; $display("FAIL rst_wd_rdy got %0d want 0", wd_rdy_o); end
        go();
        rst = 1'b0;
    endtask

    task automatic test_single();
        push_aw(5'd3, 1'b0);
        wd_vld_i = 1'b1; wd_err_i = 1'b0;
        smp();
        n_cmp++; if (wd_rdy_o !== 1'b1) begin n_err++; $display("FAIL single_wd_rdy got %0d want 1", wd_rdy_o); end
        n_cmp++; if (ostd_cnt_o !== 3'd1) begin n_err++; $display("FAIL single_ostd_q got %0d want 1", ostd_cnt_o); end
        go();
        wd_vld_i = 1'b0;
        smp();
        n_cmp++; if (s_bvalid_o !== 1'b1) begin n_err++; $display("FAIL single_bvalid got %0d want 1", s_bvalid_o); end
        n_cmp++; if (s_bid_o !== 5'd3) begin n_err++; $display("FAIL single_bid got %0d want 3", s_bid_o); end
        n_cmp++; if (s_bresp_o !== 2'b00) begin n_err++; $display("FAIL single_bresp got %0d want 0", s_bresp_o); end
        n_cmp++; if (ostd_cnt_o !== 3'd1) begin n_err++; $display("FAIL single_ostd_b got %0d want 1", ostd_cnt_o); end
        for (int i = 0; i < 3; i++) begin
            go();
            smp();
            n_cmp++; if (s_bvalid_o !== 1'b1 || s_bid_o !== 5'd3) begin n_err++; $display("FAIL single_hold vld=%0d bid=%0d want vld=1 bid=3", s_bvalid_o, s_bid_o); end
        end
        s_bready_i = 1'b1;
        go();
        s_bready_i = 1'b0;
        smp();
        n_cmp++; if (s_bvalid_o !== 1'b0) begin n_err++; $display("FAIL single_drain got %0d want 0", s_bvalid_o); end
        n_cmp++; if (ostd_cnt_o !== 3'd0) begin n_err++; $display("FAIL single_ostd_end got %0d want 0", ostd_cnt_o); end
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) push_aw(5'(i), 1'b0);
        aw_vld_i = 1'b1; aw_id_i = 5'd5; aw_decerr_i = 1'b0;
        smp();
        n_cmp++; if (aw_rdy_o !== 1'b0) begin n_err++; $display("FAIL full_aw_rdy got %0d want 0", aw_rdy_o); end
        n_cmp++; if (ostd_cnt_o !== 3'd4) begin n_err++; $display("FAIL full_ostd got %0d want 4", ostd_cnt_o); end
        go();
        smp();
        n_cmp++; if (aw_rdy_o !== 1'b0) begin n_err++; $display("FAIL full_stall got %0d want 0", aw_rdy_o); end
        s_bready_i = 1'b1; wd_vld_i = 1'b1; wd_err_i = 1'b0;
        go();
        smp();
        n_cmp++; if (s_bvalid_o !== 1'b1 || s_bid_o !== 5'd1) begin n_err++; $display("FAIL full_bid1 vld=%0d bid=%0d want vld=1 bid=1", s_bvalid_o, s_bid_o); end
        n_cmp++; if (aw_rdy_o !== 1'b1) begin n_err++; $display("FAIL full_slot_free got %0d want 1", aw_rdy_o); end
        go();
        aw_vld_i = 1'b0;
        smp();
        n_cmp++; if (s_bvalid_o !== 1'b1 || s_bid_o !== 5'd2) begin n_err++; $display("FAIL full_bid2 vld=%0d bid=%0d want vld=1 bid=2", s_bvalid_o, s_bid_o); end
        n_cmp++; if (ostd_cnt_o !== 3'd4) begin n_err++; $display("FAIL full_ostd_mid got %0d want 4", ostd_cnt_o); end
        for (int i = 3; i <= 5; i++) begin
            go();
            if (i == 5) wd_vld_i = 1'b0;
            smp();
            n_cmp++; if (s_bvalid_o !== 1'b1 || s_bid_o !== 5'(i)) begin n_err++; $display("FAIL full_bid_seq vld=%0d bid=%0d want vld=1 bid=%0d", s_bvalid_o, s_bid_o, i); end
        end
        n_cmp++; if (wd_rdy_o !== 1'b0) begin n_err++; $display("FAIL full_empty_wd_rdy got %0d want 0", wd_rdy_o); end
        go();
        s_bready_i = 1'b0;
        smp();
        n_cmp++; if (s_bvalid_o !== 1'b0 || ostd_cnt_o !== 3'd0) begin n_err++; $display("FAIL full_drain vld=%0d ostd=%0d want 0 0", s_bvalid_o, ostd_cnt_o); end
    endtask

    task automatic test_resp();
        logic [4:0] exp_id   [3];
        logic [1:0] exp_resp [3];
        logic       errs     [3];
        exp_id   = '{5'd7, 5'd6, 5'd8};
        exp_resp = '{2'b11, 2'b10, 2'b11};
        errs     = '{1'b1, 1'b1, 1'b0};
        push_aw(5'd7, 1'b1);
        push_aw(5'd6, 1'b0);
        push_aw(5'd8, 1'b1);
        s_bready_i = 1'b1; wd_vld_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wd_err_i = errs[i];
            go();
            if (i == 2) wd_vld_i = 1'b0;
            smp();
            n_cmp++; if (s_bid_o !== exp_id[i] || s_bresp_o !== exp_resp[i]) begin n_err++; $display("FAIL resp_code bid=%0d resp=%0d want bid=%0d resp=%0d", s_bid_o, s_bresp_o, exp_id[i], exp_resp[i]); end
        end
        wd_err_i = 1'b0;
        go();
        s_bready_i = 1'b0;
        smp();
        n_cmp++; if (s_bvalid_o !== 1'b0) begin n_err++; $display("FAIL resp_drain got %0d want 0", s_bvalid_o); end
    endtask

    task automatic test_w_before_aw();
        wd_vld_i = 1'b1; wd_err_i = 1'b0; s_bready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            smp();
            n_cmp++; if (wd_rdy_o !== 1'b0 || s_bvalid_o !== 1'b0) begin n_err++; $display("FAIL wfirst_hold rdy=%0d vld=%0d want 0 0", wd_rdy_o, s_bvalid_o); end
            go();
        end
        aw_vld_i = 1'b1; aw_id_i = 5'd9; aw_decerr_i = 1'b0;
        smp();
        n_cmp++; if (wd_rdy_o !== 1'b0) begin n_err++; $display("FAIL wfirst_no_bypass got %0d want 0", wd_rdy_o); end
        go();
        aw_vld_i = 1'b0;
        smp();
        n_cmp++; if (wd_rdy_o !== 1'b1) begin n_err++; $display("FAIL wfirst_take got %0d want 1", wd_rdy_o); end
        go();
        wd_vld_i = 1'b0;
        smp();
        n_cmp++; if (s_bvalid_o !== 1'b1 || s_bid_o !== 5'd9) begin n_err++; $display("FAIL wfirst_bid vld=%0d bid=%0d want vld=1 bid=9", s_bvalid_o, s_bid_o); end
        go();
        s_bready_i = 1'b0;
        smp();
        n_cmp++; if (s_bvalid_o !== 1'b0) begin n_err++; $display("FAIL wfirst_drain got %0d want 0", s_bvalid_o); end
    endtask

    task automatic test_backpressure();
        s_bready_i = 1'b0;
        push_aw(5'd10, 1'b0);
        push_aw(5'd11, 1'b0);
        wd_vld_i = 1'b1; wd_err_i = 1'b0;
        go();
        for (int i = 0; i < 10; i++) begin
            smp();
            n_cmp++; if (s_bvalid_o !== 1'b1 || s_bid_o !== 5'd10 || s_bresp_o !== 2'b00) begin n_err++; $display("FAIL bp_stable vld=%0d bid=%0d resp=%0d want 1 10 0", s_bvalid_o, s_bid_o, s_bresp_o); end
            n_cmp++; if (wd_rdy_o !== 1'b0 || ostd_cnt_o !== 3'd2) begin n_err++; $display("FAIL bp_stall rdy=%0d ostd=%0d want 0 2", wd_rdy_o, ostd_cnt_o); end
            go();
        end
        s_bready_i = 1'b1;
        smp();
        n_cmp++; if (wd_rdy_o !== 1'b1) begin n_err++; $display("FAIL bp_release got %0d want 1", wd_rdy_o); end
        go();
        wd_vld_i = 1'b0;
        smp();
        n_cmp++; if (s_bvalid_o !== 1'b1 || s_bid_o !== 5'd11) begin n_err++; $display("FAIL bp_second vld=%0d bid=%0d want vld=1 bid=11", s_bvalid_o, s_bid_o); end
        go();
        s_bready_i = 1'b0;
        smp();
        n_cmp++; if (s_bvalid_o !== 1'b0 || ostd_cnt_o !== 3'd0) begin n_err++; $display("FAIL bp_drain vld=%0d ostd=%0d want 0 0", s_bvalid_o, ostd_cnt_o); end
    endtask

    task automatic test_reset_mid();
        s_bready_i = 1'b0;
        for (int i = 20; i < 24; i++) push_aw(5'(i), 1'b0);
        wd_vld_i = 1'b1; wd_err_i = 1'b0;
        go();
        wd_vld_i = 1'b0;
        smp();
        n_cmp++; if (s_bvalid_o !== 1'b1 || ostd_cnt_o !== 3'd4) begin n_err++; $display("FAIL rmid_pre vld=%0d ostd=%0d want 1 4", s_bvalid_o, ostd_cnt_o); end
        rst = 1'b1;
        go();
        smp();
        n_cmp++; if (s_bvalid_o !== 1'b0 || ostd_cnt_o !== 3'd0) begin n_err++; $display("FAIL rmid_clear vld=%0d ostd=%0d want 0 0", s_bvalid_o, ostd_cnt_o); end
        n_cmp++; if (aw_rdy_o !== 1'b1 || wd_rdy_o !== 1'b0) begin n_err++; $display("FAIL rmid_rdy aw=%0d wd=%0d want 1 0", aw_rdy_o, wd_rdy_o); end
        go();
        rst = 1'b0;
        wd_vld_i = 1'b1; s_bready_i = 1'b1;
        go();
        smp();
        n_cmp++; if (wd_rdy_o !== 1'b0 || s_bvalid_o !== 1'b0) begin n_err++; $display("FAIL rmid_no_replay rdy=%0d vld=%0d want 0 0", wd_rdy_o, s_bvalid_o); end
        wd_vld_i = 1'b0; s_bready_i = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1;
        aw_id_i = '0; aw_decerr_i = 1'b0; aw_vld_i = 1'b0;
        wd_err_i = 1'b0; wd_vld_i = 1'b0; s_bready_i = 1'b0;
        test_reset();
        test_single();
        test_full();
        test_resp();
        test_w_before_aw();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
